// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared encodings for the memory pipeline stage: access
//               sizes, writeback-select codes, exception codes and FSM
//               state constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

   // Access size (es_mem_size)
   localparam logic [1:0] c_sz_byte  = 2'd0;
   localparam logic [1:0] c_sz_half  = 2'd1;
   localparam logic [1:0] c_sz_word  = 2'd2;
   localparam logic [1:0] c_sz_dword = 2'd3;

   // Writeback source select (es_wb_sel)
   localparam logic [2:0] c_wb_alu = 3'b000;
   localparam logic [2:0] c_wb_mem = 3'b100;
   localparam logic [2:0] c_wb_pc4 = 3'b010;

   // Exception codes (ms_excp)
   localparam logic [1:0] c_excp_none     = 2'b00;
   localparam logic [1:0] c_excp_misalign = 2'b01;
   localparam logic [1:0] c_excp_timeout  = 2'b10;

   // Stage FSM states
   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_req   = 3'd1;
   localparam logic [2:0] c_st_wait  = 3'd2;
   localparam logic [2:0] c_st_done  = 3'd3;
   localparam logic [2:0] c_st_drain = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : Data-memory request/grant/response bus.
//               master : the load/store stage (drives req/we/addr/wdata/wstrb)
//               slave  : the memory (drives gnt/rvalid/rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
   parameter int XLEN = 32
);
   logic              dmem_req;
   logic              dmem_we;
   logic [XLEN-1:0]   dmem_addr;
   logic [XLEN-1:0]   dmem_wdata;
   logic [XLEN/8-1:0] dmem_wstrb;
   logic              dmem_gnt;
   logic              dmem_rvalid;
   logic [XLEN-1:0]   dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the load/store unit.
//               Ports: size/off    - access size and byte offset in the word
//                      is_unsigned - zero-extend loads
//                      st_data     - store source, replicated into wdata
//                      wstrb       - byte strobes for the access
//                      rdata       - raw bus read data, extracted to ld_data
//                      misalign    - access not naturally aligned
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]              size,
   input  logic [$clog2(XLEN/8)-1:0] off,
   input  logic                    is_unsigned,
   input  logic [XLEN-1:0]         st_data,
   input  logic [XLEN-1:0]         rdata,
   output logic [XLEN-1:0]         wdata,
   output logic [XLEN/8-1:0]       wstrb,
   output logic [XLEN-1:0]         ld_data,
   output logic                    misalign
);
   localparam int NB = XLEN / 8;

   logic [NB-1:0]   w_base_strb;
   logic [XLEN-1:0] w_shift;
   logic [XLEN-1:0] w_word_ext;

   // Store data: replicate the access-sized datum into every lane so the
   // strobes alone select the bytes that land.
   always_comb begin
      wdata = st_data;
      case (size)
         c_sz_byte: wdata = {NB{st_data[7:0]}};
         c_sz_half: wdata = {(NB/2){st_data[15:0]}};
         c_sz_word: wdata = {(NB/4){st_data[31:0]}};
         default:   wdata = st_data;
      endcase
   end

   always_comb begin
      w_base_strb = '1;
      case (size)
         c_sz_byte: w_base_strb = NB'(1'b1);
         c_sz_half: w_base_strb = NB'(2'b11);
         c_sz_word: w_base_strb = NB'(4'hF);
         default:   w_base_strb = '1;
      endcase
   end

   assign wstrb = w_base_strb << off;

   // Load data: bring the addressed lane down to bit 0, then extend.
   assign w_shift = rdata >> {off, 3'b000};

   generate
      if (XLEN == 64) begin : g_x64
         assign w_word_ext = is_unsigned ? {32'b0, w_shift[31:0]}
                                         : {{32{w_shift[31]}}, w_shift[31:0]};
      end else begin : g_x32
         assign w_word_ext = w_shift;
      end
   endgenerate

   always_comb begin
      ld_data = w_shift;
      case (size)
         c_sz_byte: ld_data = is_unsigned ? {{(XLEN-8){1'b0}}, w_shift[7:0]}
                                          : {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
         c_sz_half: ld_data = is_unsigned ? {{(XLEN-16){1'b0}}, w_shift[15:0]}
                                          : {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
         c_sz_word: ld_data = w_word_ext;
         default:   ld_data = w_shift;
      endcase
   end

   // A dword access on a 32-bit datapath cannot be served and is reported
   // as misaligned so it never reaches the bus.
   always_comb begin
      misalign = 1'b0;
      case (size)
         c_sz_byte: misalign = 1'b0;
         c_sz_half: misalign = off[0];
         c_sz_word: misalign = |off[1:0];
         default:   misalign = (XLEN == 64) ? (|off) : 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory pipeline stage between execute and writeback.
//               Issues at most one request on a req/gnt/rvalid data bus,
//               steers store lanes, extracts/extends load data, flags
//               misaligned accesses and response timeouts, and drains an
//               in-flight response after a flush.
//               Ports: clk/rst_n        - clock, async active-low reset
//                      es_* / ms_allowin - upstream valid/allowin handshake
//                      ms_* / ws_allowin - downstream result and handshake
//                      flush            - kill the held instruction
//                      dmem             - data-memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
   import mem_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            es_to_ms_valid,
   output logic            ms_allowin,
   output logic            ms_to_ws_valid,
   input  logic            ws_allowin,
   input  logic            flush,
   input  logic [XLEN-1:0] es_alu_result,
   input  logic [4:0]      es_rd,
   input  logic            es_rd_wen,
   input  logic            es_mem_re,
   input  logic            es_mem_we,
   input  logic [1:0]      es_mem_size,
   input  logic            es_mem_unsigned,
   input  logic [2:0]      es_wb_sel,
   input  logic [XLEN-1:0] es_pc,
   input  logic [XLEN-1:0] es_st_data,
   mem_stage_lsu_if.master dmem,
   output logic [4:0]      ms_rd,
   output logic            ms_rd_wen,
   output logic [XLEN-1:0] ms_wb_data,
   output logic [XLEN-1:0] ms_pc,
   output logic [1:0]      ms_excp
);
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] c_cnt_last = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   logic [2:0]       r_state;
   logic             r_valid;
   logic [XLEN-1:0]  r_alu_result;
   logic [4:0]       r_rd;
   logic             r_rd_wen;
   logic             r_mem_re;
   logic             r_mem_we;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [2:0]       r_wb_sel;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_st_data;
   logic [XLEN-1:0]  r_ld_data;
   logic [1:0]       r_excp;
   logic [CNT_W-1:0] r_cnt;

   logic             w_ready_go;
   logic             w_accept;
   logic             w_es_mem;
   logic             w_es_misalign;
   logic             w_timeout;
   logic             w_req;
   logic             w_use_latched;
   logic [1:0]       w_al_size;
   logic [OFF_W-1:0] w_al_off;
   logic [XLEN-1:0]  w_wdata;
   logic [XLEN/8-1:0] w_wstrb;
   logic [XLEN-1:0]  w_ld_data;
   logic [XLEN-1:0]  w_wb_data;

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   assign w_ready_go     = (r_state == c_st_done);
   assign ms_allowin     = (!r_valid || (w_ready_go && ws_allowin)) && (r_state != c_st_drain);
   assign ms_to_ws_valid = r_valid && w_ready_go && !flush;
   assign w_accept       = es_to_ms_valid && ms_allowin;
   assign w_es_mem       = es_mem_re || es_mem_we;
   assign w_timeout      = (TIMEOUT != 0) && (r_cnt == c_cnt_last);

   // ---------------------------------------------------------------------
   // Lane logic. Accepts only happen in IDLE/DONE, while lane outputs are
   // only consumed in REQ/WAIT, so one instance serves both: it decodes
   // the incoming op for the alignment check and the held op otherwise.
   // ---------------------------------------------------------------------
   assign w_use_latched = (r_state == c_st_req) || (r_state == c_st_wait);
   assign w_al_size     = w_use_latched ? r_size : es_mem_size;
   assign w_al_off      = w_use_latched ? r_alu_result[OFF_W-1:0] : es_alu_result[OFF_W-1:0];

   lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .size        (w_al_size),
      .off         (w_al_off),
      .is_unsigned (r_unsigned),
      .st_data     (r_st_data),
      .rdata       (dmem.dmem_rdata),
      .wdata       (w_wdata),
      .wstrb       (w_wstrb),
      .ld_data     (w_ld_data),
      .misalign    (w_es_misalign)
   );

   // ---------------------------------------------------------------------
   // Bus outputs: everything is a function of held state, so the request
   // stays stable until granted.
   // ---------------------------------------------------------------------
   assign w_req           = (r_state == c_st_req);
   assign dmem.dmem_req   = w_req;
   assign dmem.dmem_we    = w_req && r_mem_we;
   assign dmem.dmem_addr  = w_req ? {r_alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign dmem.dmem_wdata = (w_req && r_mem_we) ? w_wdata : '0;
   assign dmem.dmem_wstrb = w_req ? w_wstrb : '0;

   // ---------------------------------------------------------------------
   // Stage FSM and held fields
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_st_idle;
         r_valid      <= 1'b0;
         r_alu_result <= '0;
         r_rd         <= '0;
         r_rd_wen     <= 1'b0;
         r_mem_re     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_size       <= '0;
         r_unsigned   <= 1'b0;
         r_wb_sel     <= '0;
         r_pc         <= '0;
         r_st_data    <= '0;
         r_ld_data    <= '0;
         r_excp       <= c_excp_none;
      end else if (w_accept) begin
         // An accept also retires (or, under flush, kills) whatever was in
         // DONE, so back-to-back ops need no bubble.
         r_valid      <= 1'b1;
         r_state      <= (w_es_mem && !w_es_misalign) ? c_st_req : c_st_done;
         r_excp       <= (w_es_mem && w_es_misalign) ? c_excp_misalign : c_excp_none;
         r_alu_result <= es_alu_result;
         r_rd         <= es_rd;
         r_rd_wen     <= es_rd_wen;
         r_mem_re     <= es_mem_re;
         r_mem_we     <= es_mem_we;
         r_size       <= es_mem_size;
         r_unsigned   <= es_mem_unsigned;
         r_wb_sel     <= es_wb_sel;
         r_pc         <= es_pc;
         r_st_data    <= es_st_data;
         r_ld_data    <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_state <= c_st_idle;
            end
            c_st_req: begin
               if (dmem.dmem_gnt) begin
                  // A grant coinciding with flush still owes a response.
                  r_state <= flush ? c_st_drain : c_st_wait;
                  if (flush) r_valid <= 1'b0;
               end else if (flush) begin
                  r_state <= c_st_idle;
                  r_valid <= 1'b0;
               end
            end
            c_st_wait: begin
               if (flush) begin
                  r_valid <= 1'b0;
                  r_state <= (dmem.dmem_rvalid || w_timeout) ? c_st_idle : c_st_drain;
               end else if (dmem.dmem_rvalid) begin
                  if (r_mem_re) r_ld_data <= w_ld_data;
                  r_state <= c_st_done;
               end else if (w_timeout) begin
                  r_excp  <= c_excp_timeout;
                  r_state <= c_st_done;
               end
            end
            c_st_done: begin
               if (ws_allowin || flush) begin
                  r_valid <= 1'b0;
                  r_state <= c_st_idle;
               end
            end
            c_st_drain: begin
               if (dmem.dmem_rvalid || w_timeout) r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // Response timer: cleared on grant, runs while a response is owed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_req && dmem.dmem_gnt) begin
         r_cnt <= '0;
      end else if (((r_state == c_st_wait) || (r_state == c_st_drain)) && !w_timeout) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Writeback outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_wb_data = '0;
      case (r_wb_sel)
         c_wb_alu: w_wb_data = r_alu_result;
         c_wb_mem: w_wb_data = r_ld_data;
         c_wb_pc4: w_wb_data = r_pc + XLEN'(4);
         default:  w_wb_data = '0;
      endcase
   end

   assign ms_wb_data = w_wb_data;
   assign ms_rd      = r_rd;
   assign ms_rd_wen  = r_rd_wen && (r_excp == c_excp_none);
   assign ms_pc      = r_pc;
   assign ms_excp    = r_excp;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Directed self-checking bench for mem_stage_lsu (XLEN=32,
//               TIMEOUT=4). The bench plays the memory side of the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
   import mem_stage_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        es_to_ms_valid;
   logic        ms_allowin;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic        flush;
   logic [31:0] es_alu_result;
   logic [4:0]  es_rd;
   logic        es_rd_wen;
   logic        es_mem_re;
   logic        es_mem_we;
   logic [1:0]  es_mem_size;
   logic        es_mem_unsigned;
   logic [2:0]  es_wb_sel;
   logic [31:0] es_pc;
   logic [31:0] es_st_data;
   logic [4:0]  ms_rd;
   logic        ms_rd_wen;
   logic [31:0] ms_wb_data;
   logic [31:0] ms_pc;
   logic [1:0]  ms_excp;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_lsu_if #(.XLEN(32)) dmem_if ();

   mem_stage_lsu #(
      .XLEN    (32),
      .TIMEOUT (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .es_to_ms_valid  (es_to_ms_valid),
      .ms_allowin      (ms_allowin),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ws_allowin      (ws_allowin),
      .flush           (flush),
      .es_alu_result   (es_alu_result),
      .es_rd           (es_rd),
      .es_rd_wen       (es_rd_wen),
      .es_mem_re       (es_mem_re),
      .es_mem_we       (es_mem_we),
      .es_mem_size     (es_mem_size),
      .es_mem_unsigned (es_mem_unsigned),
      .es_wb_sel       (es_wb_sel),
      .es_pc           (es_pc),
      .es_st_data      (es_st_data),
      .dmem            (dmem_if),
      .ms_rd           (ms_rd),
      .ms_rd_wen       (ms_rd_wen),
      .ms_wb_data      (ms_wb_data),
      .ms_pc           (ms_pc),
      .ms_excp         (ms_excp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic send(input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] st,
                       input logic [4:0] rd, input logic rd_wen, input logic re, input logic we,
                       input logic [1:0] size, input logic uns, input logic [2:0] wbsel);
      es_to_ms_valid  = 1'b1;
      es_alu_result   = addr;
      es_pc           = pc;
      es_st_data      = st;
      es_rd           = rd;
      es_rd_wen       = rd_wen;
      es_mem_re       = re;
      es_mem_we       = we;
      es_mem_size     = size;
      es_mem_unsigned = uns;
      es_wb_sel       = wbsel;
   endtask

   // Accept, grant at once, return rvalid after 'delay' idle WAIT cycles.
   // Leaves the stage in DONE with ws_allowin as set by the caller.
   task automatic mem_op(input logic [31:0] addr, input logic [31:0] st, input logic re,
                         input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] rdata, input int delay);
      send(addr, 32'h0, st, 5'd7, re, re, we, size, uns, re ? c_wb_mem : c_wb_alu);
      tick();
      es_to_ms_valid = 1'b0;
      dmem_if.dmem_gnt = 1'b1;
      tick();
      dmem_if.dmem_gnt = 1'b0;
      repeat (delay) tick();
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata  = rdata;
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      dmem_if.dmem_rdata  = 32'h0;
      settle();
   endtask

   initial begin
      rst_n = 1'b0;
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b1;
      flush = 1'b0;
      es_alu_result = '0; es_rd = '0; es_rd_wen = 1'b0; es_mem_re = 1'b0;
      es_mem_we = 1'b0; es_mem_size = '0; es_mem_unsigned = 1'b0; es_wb_sel = '0;
      es_pc = '0; es_st_data = '0;
      dmem_if.dmem_gnt = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      dmem_if.dmem_rdata = '0;

      // ---- reset ----
      tick();
      settle();
      chk("rst_allowin", ms_allowin, 1);
      chk("rst_to_ws", ms_to_ws_valid, 0);
      chk("rst_req", dmem_if.dmem_req, 0);
      chk("rst_excp", ms_excp, 0);
      chk("rst_wb_data", ms_wb_data, 0);
      chk("rst_rd_wen", ms_rd_wen, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // ---- store byte at 0x1003 ----
      send(32'h1003, 32'h0, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, c_sz_byte, 1'b0, c_wb_alu);
      settle();
      chk("sb_allowin", ms_allowin, 1);
      tick();
      es_to_ms_valid = 1'b0;
      settle();
      chk("sb_req", dmem_if.dmem_req, 1);
      chk("sb_we", dmem_if.dmem_we, 1);
      chk("sb_addr", dmem_if.dmem_addr, 32'h1000);
      chk("sb_wdata", dmem_if.dmem_wdata, 32'hABAB_ABAB);
      chk("sb_wstrb", dmem_if.dmem_wstrb, 4'b1000);
      tick();
      settle();
      chk("sb_req_hold", dmem_if.dmem_req, 1);
      chk("sb_addr_hold", dmem_if.dmem_addr, 32'h1000);
      dmem_if.dmem_gnt = 1'b1;
      tick();
      dmem_if.dmem_gnt = 1'b0;
      settle();
      chk("sb_req_drop", dmem_if.dmem_req, 0);
      chk("sb_wait_allowin", ms_allowin, 0);
      chk("sb_wait_to_ws", ms_to_ws_valid, 0);
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata = 32'hDEAD_BEEF;
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      settle();
      chk("sb_done_to_ws", ms_to_ws_valid, 1);
      chk("sb_wb_alu", ms_wb_data, 32'h1003);
      chk("sb_excp", ms_excp, 0);
      tick();
      settle();
      chk("sb_retired", ms_to_ws_valid, 0);

      // ---- signed half load at 0x2002, rvalid on third WAIT cycle ----
      send(32'h2002, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, c_sz_half, 1'b0, c_wb_mem);
      tick();
      es_to_ms_valid = 1'b0;
      settle();
      chk("lh_addr", dmem_if.dmem_addr, 32'h2000);
      chk("lh_we", dmem_if.dmem_we, 0);
      dmem_if.dmem_gnt = 1'b1;
      tick();
      dmem_if.dmem_gnt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         settle();
         chk("lh_wait_to_ws", ms_to_ws_valid, 0);
      end
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata = 32'h8001_1234;
      settle();
      chk("lh_rvalid_cycle_to_ws", ms_to_ws_valid, 0);
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      settle();
      chk("lh_to_ws", ms_to_ws_valid, 1);
      chk("lh_data", ms_wb_data, 32'hFFFF_8001);
      chk("lh_rd", ms_rd, 5);
      chk("lh_rd_wen", ms_rd_wen, 1);
      tick();

      // ---- misaligned word load at 0x3001 ----
      send(32'h3001, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, c_sz_word, 1'b0, c_wb_mem);
      tick();
      es_to_ms_valid = 1'b0;
      settle();
      chk("mis_req", dmem_if.dmem_req, 0);
      chk("mis_to_ws", ms_to_ws_valid, 1);
      chk("mis_excp", ms_excp, 2'b01);
      chk("mis_rd_wen", ms_rd_wen, 0);
      tick();

      // ---- flush during WAIT, response 2 cycles later ----
      send(32'h4000, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, c_sz_word, 1'b0, c_wb_mem);
      tick();
      es_to_ms_valid = 1'b0;
      dmem_if.dmem_gnt = 1'b1;
      tick();
      dmem_if.dmem_gnt = 1'b0;
      flush = 1'b1;
      settle();
      chk("fl_to_ws", ms_to_ws_valid, 0);
      tick();
      flush = 1'b0;
      settle();
      chk("fl_drain_allowin", ms_allowin, 0);
      chk("fl_drain_to_ws", ms_to_ws_valid, 0);
      tick();
      settle();
      chk("fl_drain_allowin2", ms_allowin, 0);
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata = 32'h1111_2222;
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      settle();
      chk("fl_idle_allowin", ms_allowin, 1);
      chk("fl_idle_to_ws", ms_to_ws_valid, 0);

      // stray rvalid in IDLE must be ignored
      dmem_if.dmem_rvalid = 1'b1;
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      settle();
      chk("stray_rvalid_to_ws", ms_to_ws_valid, 0);
      chk("stray_rvalid_allowin", ms_allowin, 1);

      // ---- response timeout (TIMEOUT=4) ----
      send(32'h5000, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, c_sz_word, 1'b0, c_wb_mem);
      tick();
      es_to_ms_valid = 1'b0;
      dmem_if.dmem_gnt = 1'b1;
      tick();
      dmem_if.dmem_gnt = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         settle();
         chk("to_pending", ms_to_ws_valid, 0);
      end
      tick();
      settle();
      chk("to_to_ws", ms_to_ws_valid, 1);
      chk("to_excp", ms_excp, 2'b10);
      chk("to_rd_wen", ms_rd_wen, 0);
      tick();
      settle();
      chk("to_resume_allowin", ms_allowin, 1);

      // ---- back-to-back ALU ops, then downstream stall ----
      send(32'h11, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, c_sz_word, 1'b0, c_wb_alu);
      tick();
      send(32'h22, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, c_sz_word, 1'b0, c_wb_alu);
      settle();
      chk("b2b1_to_ws", ms_to_ws_valid, 1);
      chk("b2b1_data", ms_wb_data, 32'h11);
      chk("b2b1_allowin", ms_allowin, 1);
      tick();
      send(32'h0, 32'hFFFF_FFFC, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, c_sz_word, 1'b0, c_wb_pc4);
      settle();
      chk("b2b2_data", ms_wb_data, 32'h22);
      chk("b2b2_rd", ms_rd, 2);
      tick();
      send(32'h44, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, c_sz_word, 1'b0, c_wb_alu);
      ws_allowin = 1'b0;
      settle();
      chk("pc4_wrap", ms_wb_data, 32'h0);
      chk("stall_allowin", ms_allowin, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         settle();
         chk("stall_rd_hold", ms_rd, 3);
         chk("stall_pc_hold", ms_pc, 32'hFFFF_FFFC);
         chk("stall_allowin_hold", ms_allowin, 0);
         chk("stall_to_ws_hold", ms_to_ws_valid, 1);
      end
      ws_allowin = 1'b1;
      settle();
      chk("unstall_allowin", ms_allowin, 1);
      tick();
      send(32'h0, 32'h0000_0100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, c_sz_word, 1'b0, c_wb_pc4);
      settle();
      chk("op4_data", ms_wb_data, 32'h44);
      chk("op4_rd", ms_rd, 4);
      tick();
      send(32'h55, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, c_sz_word, 1'b0, 3'b111);
      settle();
      chk("pc4_data", ms_wb_data, 32'h104);
      tick();
      es_to_ms_valid = 1'b0;
      settle();
      chk("wbsel_other", ms_wb_data, 32'h0);
      chk("wbsel_other_to_ws", ms_to_ws_valid, 1);
      tick();
      settle();
      chk("b2b_drained", ms_to_ws_valid, 0);

      // ---- half store lanes and unsigned byte load ----
      send(32'h6002, 32'h0, 32'h1234_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, c_sz_half, 1'b0, c_wb_alu);
      tick();
      es_to_ms_valid = 1'b0;
      settle();
      chk("sh_addr", dmem_if.dmem_addr, 32'h6000);
      chk("sh_wdata", dmem_if.dmem_wdata, 32'hBEEF_BEEF);
      chk("sh_wstrb", dmem_if.dmem_wstrb, 4'b1100);
      dmem_if.dmem_gnt = 1'b1;
      tick();
      dmem_if.dmem_gnt = 1'b0;
      dmem_if.dmem_rvalid = 1'b1;
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      settle();
      chk("sh_done", ms_to_ws_valid, 1);
      tick();

      mem_op(32'h7001, 32'h0, 1'b1, 1'b0, c_sz_byte, 1'b1, 32'h1234_80FF, 1);
      chk("lbu_data", ms_wb_data, 32'h0000_0080);
      tick();
      mem_op(32'h7001, 32'h0, 1'b1, 1'b0, c_sz_byte, 1'b0, 32'h1234_80FF, 0);
      chk("lb_data", ms_wb_data, 32'hFFFF_FF80);
      tick();
      mem_op(32'h7002, 32'h0, 1'b1, 1'b0, c_sz_half, 1'b1, 32'h8001_1234, 0);
      chk("lhu_data", ms_wb_data, 32'h0000_8001);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised memory pipeline stage between execute and writeback.
- Adds a variable-latency request/grant/response data-memory port, byte/half/word(/dword) access with lane steering and sign extension, misalignment detection, flush with in-flight drain, and a response timeout.
- Uses the same valid/allowin handshake as the rest of the pipeline.
- Writeback data is not valid until the memory response has arrived.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TIMEOUT, 255, cycles allowed from grant to rvalid before a bus error is flagged; 0 disables the timeout.
OFF_W, $clog2(XLEN/8), byte-offset bits (derived; not overridable).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
es_to_ms_valid  in  1  execute stage holds a valid instruction
ms_allowin  out  1  stage can accept an instruction this cycle
ms_to_ws_valid  out  1  result valid toward writeback
ws_allowin  in  1  writeback can accept
flush  in  1  kill the instruction held in this stage
es_alu_result  in  XLEN  ALU result / effective address
es_rd  in  5  destination register
es_rd_wen  in  1  register write enable
es_mem_re  in  1  load
es_mem_we  in  1  store
es_mem_size  in  2  0=byte, 1=half, 2=word, 3=dword (XLEN=64 only)
es_mem_unsigned  in  1  zero-extend loads
es_wb_sel  in  3  000 alu, 100 mem, 010 pc+4
es_pc  in  XLEN  instruction PC
es_st_data  in  XLEN  store source data
dmem_req  out  1  memory request
dmem_we  out  1  write request
dmem_addr  out  XLEN  address, low OFF_W bits forced to 0
dmem_wdata  out  XLEN  lane-replicated store data
dmem_wstrb  out  XLEN/8  byte strobes
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data / store acknowledge valid
dmem_rdata  in  XLEN  read data
ms_rd  out  5  destination register
ms_rd_wen  out  1  write enable; forced 0 on any exception
ms_wb_data  out  XLEN  writeback data
ms_pc  out  XLEN  PC
ms_excp  out  2  01 misaligned, 10 bus timeout, 00 none

Behaviour:
- Reset: ms_valid=0, state IDLE, dmem_req=0, every registered field 0, ms_excp=0. ms_allowin=1 and ms_to_ws_valid=0 while in reset.
- Accept: when es_to_ms_valid && ms_allowin, latch all es_* fields and set ms_valid=1.
- ms_allowin = (!ms_valid || (ms_ready_go && ws_allowin)) && state!=DRAIN.
- ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE to REQ: an aligned memory op is accepted. Non-memory and misaligned ops go directly to DONE; a misaligned op issues no request and sets ms_excp=01.
  - REQ: dmem_req=1 with address, strobes and data held stable until dmem_gnt, then move to WAIT.
  - WAIT: on dmem_rvalid, capture the load result into ms_wb_data (stores ignore rdata) and move to DONE. The timeout counter starts at grant; when it reaches TIMEOUT, move to DONE with ms_excp=10.
  - DONE: ms_ready_go=1. On ws_allowin, return to IDLE, or go straight to REQ/DONE if a new op is accepted in the same cycle (back-to-back, no bubble).
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; dword requires addr[2:0]=0.
- Stores: byte data replicated to all lanes and half data to all half-lanes. wstrb is 1/3/F/FF shifted left by addr[OFF_W-1:0].
- Loads: rdata shifted right by offset×8, then sign- or zero-extended from the access size.
- Writeback mux:
  - wb_sel 000: alu_result.
  - wb_sel 100: load result.
  - wb_sel 010: pc+4, wrapping modulo 2^XLEN.
  - any other value: 0.
- Flush:
  - In IDLE/REQ-before-grant/DONE: ms_valid clears next cycle and dmem_req drops.
  - In WAIT: go to DRAIN. ms_valid=0; the pending rvalid is consumed and discarded (or timeout is reached), then IDLE.
  - flush and accept in the same cycle: the accept wins only when state!=WAIT.
- At most one outstanding request. dmem_rvalid outside WAIT/DRAIN is ignored.

Decomposition:
- Package mem_stage_pkg holds: size encodings, wb_sel encodings, ms_excp codes, FSM state enum.
- Sub-module lsu_align (combinational): store lane steering and strobes, load extraction and extension, misalign detect. Parametrised by XLEN.

Test Plan:
- XLEN=32, store byte: addr 0x1003, data 0xAB → one request, wdata 0xABABABAB, wstrb 1000, addr 0x1000.
- Load half signed at 0x2002, rdata 0x8001_1234 after 3-cycle rvalid delay → ms_wb_data 0xFFFF8001; ms_to_ws_valid rises the cycle after rvalid.
- Load word at 0x3001 → no dmem_req, ms_excp=01, ms_rd_wen=0, result valid the cycle after accept.
- Flush asserted during WAIT, rvalid 2 cycles later → ms_allowin=0 until rvalid, no ms_to_ws_valid, then IDLE.
- TIMEOUT=4, no rvalid ever arrives → ms_excp=10 presented 4 cycles after grant; pipeline resumes afterwards.
- Back-to-back ALU ops with ws_allowin=1 → one result per cycle. With ws_allowin low for 2 cycles → outputs held stable and ms_allowin=0.
